// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Control, ROM and decoder-facing signal bundle for fetch_unit.
//                The slave modport is the fetch unit's view of the bundle.
//                The master modport is the view of the surrounding
//                core/decoder/ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic       start_i;
    logic       stall_i;
    logic       branch_en_i;
    logic [6:0] branch_target_i;
    logic       halt_i;
    logic [7:0] rom_data_i;
    logic [6:0] rom_addr_o;
    logic [6:0] pc_o;
    logic [7:0] instr_o;
    logic       instr_valid_o;
    logic       done_o;

    modport slave (
        input  start_i,
        input  stall_i,
        input  branch_en_i,
        input  branch_target_i,
        input  halt_i,
        input  rom_data_i,
        output rom_addr_o,
        output pc_o,
        output instr_o,
        output instr_valid_o,
        output done_o
    );

    modport master (
        output start_i,
        output stall_i,
        output branch_en_i,
        output branch_target_i,
        output halt_i,
        output rom_data_i,
        input  rom_addr_o,
        input  pc_o,
        input  instr_o,
        input  instr_valid_o,
        input  done_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction fetch from a combinational 128-entry
//                ROM, with stall, branch redirect (one-cycle bubble) and a
//                sticky halt state. Reset is asynchronous and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit (
    input  wire         clk_i,
    input  wire         rst_n_i,
    fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t     r_state;
    logic [6:0] r_pc;
    logic [7:0] r_instr;
    logic       r_valid;
    logic       r_done;

    // Decoder requests are honoured only for a live instruction in RUN.
    logic w_halt_req;
    logic w_branch_req;

    assign w_halt_req   = bus.halt_i      && r_valid;
    assign w_branch_req = bus.branch_en_i && r_valid;

    // Fetch state machine: halt > branch > stall > sequential fetch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_pc    <= 7'd0;
            r_instr <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_halt_req) begin
                        r_state <= ST_HALT;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_branch_req) begin
                        // The sequential fetch of this cycle is discarded.
                        r_pc    <= bus.branch_target_i;
                        r_valid <= 1'b0;
                    end else if (!bus.stall_i) begin
                        r_instr <= bus.rom_data_i;
                        r_valid <= 1'b1;
                        r_pc    <= r_pc + 7'd1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.rom_addr_o    = r_pc;
    assign bus.instr_o       = r_instr;
    assign bus.instr_valid_o = r_valid;
    assign bus.done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with directed scenarios
//                and randomized control traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b1;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Instruction ROM: ROM[a] = a + 8'h10, combinational.
    assign bus.rom_data_i = {1'b0, bus.rom_addr_o} + 8'h10;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    int  m_pc;
    int  m_instr;
    bit  m_run;
    bit  m_halt;
    bit  m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc    = 0;
        m_instr = 0;
        m_run   = 0;
        m_halt  = 0;
        m_valid = 0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        if (m_halt) begin
            // Only reset leaves HALT.
        end else if (!m_run) begin
            if (bus.start_i) m_run = 1;
        end else if (m_valid && bus.halt_i) begin
            m_run   = 0;
            m_halt  = 1;
            m_valid = 0;
        end else if (m_valid && bus.branch_en_i) begin
            m_pc    = int'(bus.branch_target_i);
            m_valid = 0;
        end else if (!bus.stall_i) begin
            m_instr = (m_pc + 16) % 256;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 128;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(bus.pc_o),          32'(m_pc));
        chk({tag, ".addr"},  32'(bus.rom_addr_o),    32'(m_pc));
        chk({tag, ".instr"}, 32'(bus.instr_o),       32'(m_instr));
        chk({tag, ".valid"}, 32'(bus.instr_valid_o), 32'(m_valid));
        chk({tag, ".done"},  32'(bus.done_o),        32'(m_halt));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        bus.start_i         = 1'b0;
        bus.stall_i         = 1'b0;
        bus.branch_en_i     = 1'b0;
        bus.branch_target_i = 7'd0;
        bus.halt_i          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic reset_and_start();
        do_reset();
        bus.start_i = 1'b1;
        tick("start");
        bus.start_i = 1'b0;
    endtask

    // Free-run until the DUT pc shows the target with a valid instruction.
    task automatic run_to(input int target);
        int budget;
        budget = 300;
        while (!(bus.pc_o == 7'(target) && bus.instr_valid_o) && budget > 0) begin
            tick("run");
            budget--;
        end
        if (budget == 0) chk("run_to_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        clear_inputs();
        #2;

        // First instructions after start
        reset_and_start();
        chk("idle_to_run.pc", 32'(bus.pc_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick("seq");
            chk("seq.instr", 32'(bus.instr_o), 32'(8'h10 + k));
            chk("seq.pc",    32'(bus.pc_o),    32'(k + 1));
        end

        // PC wrap 127 -> 0
        run_to(127);
        tick("wrap");
        chk("wrap.pc",    32'(bus.pc_o),    32'd0);
        chk("wrap.instr", 32'(bus.instr_o), 32'h8F);
        tick("wrap2");
        chk("wrap2.instr", 32'(bus.instr_o), 32'h10);

        // Branch at pc 5 to 40, held two cycles: second is ignored in the bubble
        reset_and_start();
        run_to(5);
        bus.branch_en_i     = 1'b1;
        bus.branch_target_i = 7'd40;
        tick("br");
        chk("br.pc",    32'(bus.pc_o),          32'd40);
        chk("br.valid", 32'(bus.instr_valid_o), 32'd0);
        tick("br2");
        bus.branch_en_i = 1'b0;
        chk("br2.instr", 32'(bus.instr_o),       32'h38);
        chk("br2.valid", 32'(bus.instr_valid_o), 32'd1);
        chk("br2.pc",    32'(bus.pc_o),          32'd41);

        // Stall three cycles at pc 9
        reset_and_start();
        run_to(9);
        bus.stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            chk("stall.pc",    32'(bus.pc_o),    32'd9);
            chk("stall.instr", 32'(bus.instr_o), 32'h18);
        end
        bus.stall_i = 1'b0;
        tick("unstall");
        chk("unstall.instr", 32'(bus.instr_o), 32'h19);

        // Halt together with branch at pc 12; start ignored afterwards
        reset_and_start();
        run_to(12);
        bus.halt_i          = 1'b1;
        bus.branch_en_i     = 1'b1;
        bus.branch_target_i = 7'd3;
        tick("halt");
        chk("halt.done",  32'(bus.done_o),        32'd1);
        chk("halt.pc",    32'(bus.pc_o),          32'd12);
        chk("halt.valid", 32'(bus.instr_valid_o), 32'd0);
        clear_inputs();
        bus.start_i = 1'b1;
        for (int k = 0; k < 3; k++) tick("halted");
        chk("halted.done", 32'(bus.done_o), 32'd1);
        clear_inputs();

        // Asynchronous reset between edges at pc 20
        reset_and_start();
        run_to(20);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async.pc",    32'(bus.pc_o),          32'd0);
        chk("async.valid", 32'(bus.instr_valid_o), 32'd0);
        chk("async.done",  32'(bus.done_o),        32'd0);
        chk("async.instr", 32'(bus.instr_o),       32'h00);
        model_reset();
        @(negedge clk_i);

        // Start held high across reset release
        bus.start_i = 1'b1;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick("hold_start");
        bus.start_i = 1'b0;
        tick("hold_start2");
        chk("hold_start.instr", 32'(bus.instr_o), 32'h10);

        // Randomized control traffic
        reset_and_start();
        for (int n = 0; n < 600; n++) begin
            bus.start_i         = ($urandom_range(0, 3) == 0);
            bus.stall_i         = ($urandom_range(0, 3) == 0);
            bus.branch_en_i     = ($urandom_range(0, 6) == 0);
            bus.branch_target_i = 7'($urandom_range(0, 127));
            bus.halt_i          = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
